// File: rtl/data_mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with a fixed wait-state delay.
// Optional build macro DMEM_ALIGN_CHECK_EN rejects requests whose byte address is not word-aligned.
module data_mem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is accepted on a rising edge with req_valid && req_ready;
  // a response is consumed on a rising edge with resp_valid && resp_ready.
  // The initiator must hold resp_ready's meaning only while resp_valid is high.

  localparam int AW = $clog2(DEPTH);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH];

  logic          accept;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          hi_err;
  logic          misalign;
  logic          acc_err;
  logic          enter_resp;
  logic          mem_we;

  assign accept = req_valid && (state_q == ST_IDLE);

  // With WAIT = 0 the access happens on the accept edge itself, so the live inputs are used there.
  assign acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign hi_err    = |(acc_addr >> (AW + 2));
  assign misalign  = |acc_addr[1:0];
  assign acc_err   = hi_err || (ALIGN_EN && misalign);

  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign mem_we     = enter_resp && acc_we && !acc_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_d   = 4'(WAIT);
          state_d = (WAIT == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    resp_valid  = (state_q == ST_RESP);
    resp_rdata  = (state_q == ST_RESP) ? rdata_q : 32'd0;
    resp_err    = (state_q == ST_RESP) ? err_q : 1'b0;
    dbg_state_o = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= acc_err;
      rdata_q <= (acc_we || acc_err) ? 32'd0 : mem_q[acc_idx];
    end else if ((state_q == ST_RESP) && resp_ready) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one WAIT=2 instance and one WAIT=0 instance on shared stimulus.
// Build with or without DMEM_ALIGN_CHECK_EN to match the design under test.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rready;
  logic        sel;

  logic        ready2, ready0, ready;
  logic        rv2, rv0, resp_valid;
  logic [31:0] rd2, rd0, resp_rdata;
  logic        er2, er0, resp_err;
  logic [1:0]  st2, st0, dbg_state;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid & ~sel), .req_ready(ready2),
    .req_we(we), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv2), .resp_ready(rready & ~sel),
    .resp_rdata(rd2), .resp_err(er2), .dbg_state_o(st2)
  );

  data_mem_responder #(.DEPTH(256), .WAIT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid & sel), .req_ready(ready0),
    .req_we(we), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv0), .resp_ready(rready & sel),
    .resp_rdata(rd0), .resp_err(er0), .dbg_state_o(st0)
  );

  assign ready      = sel ? ready0 : ready2;
  assign resp_valid = sel ? rv0 : rv2;
  assign resp_rdata = sel ? rd0 : rd2;
  assign resp_err   = sel ? er0 : er2;
  assign dbg_state  = sel ? st0 : st2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request from a negedge and drop it (with scrambled fields) just after the accept edge.
  task automatic issue(input logic we_i, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", {31'd0, ready}, 32'd1);
    valid = 1'b1;
    we    = we_i;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
    we    = ~we_i;
    addr  = 32'hFFFF_FFFF;
    wdata = 32'h0BAD_0BAD;
  endtask

  // Cycles counted from the accept edge: 1 = the cycle right after it.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
  endtask

  task automatic consume();
    rready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  task automatic xfer(input logic we_i, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    issue(we_i, a, d);
    wait_resp(lat);
    rd = resp_rdata;
    er = resp_err;
    consume();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    rst_n = 1'b0; valid = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    rready = 1'b0; sel = 1'b0;
    #1;
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", {31'd0, ready}, 32'd1);

    // WAIT=2 instance
    xfer(1'b1, 32'h0000_0000, 32'h1111_1111, rd, er, lat);
    check("pre0_err", {31'd0, er}, 32'd0);
    check("pre0_rdata", rd, 32'd0);

    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat);
    check("st10_lat", lat, 32'd3);
    check("st10_err", {31'd0, er}, 32'd0);
    check("st10_rdata", rd, 32'd0);

    xfer(1'b0, 32'h0000_0010, 32'd0, rd, er, lat);
    check("ld10_lat", lat, 32'd3);
    check("ld10_rdata", rd, 32'hDEAD_BEEF);
    check("ld10_err", {31'd0, er}, 32'd0);

    xfer(1'b0, 32'h0000_0012, 32'd0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("ld12_err", {31'd0, er}, 32'd1);
    check("ld12_rdata", rd, 32'd0);
`else
    check("ld12_err", {31'd0, er}, 32'd0);
    check("ld12_rdata", rd, 32'hDEAD_BEEF);
`endif

    xfer(1'b1, 32'h0000_0400, 32'h5A5A_5A5A, rd, er, lat);
    check("st400_err", {31'd0, er}, 32'd1);
    check("st400_rdata", rd, 32'd0);
    check("st400_lat", lat, 32'd3);
    xfer(1'b0, 32'h0000_0000, 32'd0, rd, er, lat);
    check("ld0_rdata", rd, 32'h1111_1111);
    check("ld0_err", {31'd0, er}, 32'd0);

    // Stall in RESP with a competing request held up
    issue(1'b0, 32'h0000_0010, 32'd0);
    wait_resp(lat);
    check("stall_lat", lat, 32'd3);
    valid = 1'b1; we = 1'b1; addr = 32'h0000_0000; wdata = 32'h7777_7777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_rdata", resp_rdata, 32'hDEAD_BEEF);
      check("stall_ready", {31'd0, ready}, 32'd0);
    end
    consume();
    @(negedge clk);
    check("leave_state", {30'd0, dbg_state}, 32'd0);
    check("leave_resp_valid", {31'd0, resp_valid}, 32'd0);
    valid = 1'b0;
    xfer(1'b0, 32'h0000_0000, 32'd0, rd, er, lat);
    check("noaccept_ld0", rd, 32'h1111_1111);

    // Reset during WAIT drops a pending store
    xfer(1'b1, 32'h0000_0020, 32'h1234_5678, rd, er, lat);
    issue(1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    @(negedge clk);
    check("mid_state_wait", {30'd0, dbg_state}, 32'd1);
    check("mid_rdata_wait", resp_rdata, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_rdata", resp_rdata, 32'd0);
    check("mid_rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, 32'h0000_0020, 32'd0, rd, er, lat);
    check("ld20_rdata", rd, 32'h1234_5678);
    check("ld20_lat", lat, 32'd3);

    // WAIT=0 instance
    sel = 1'b1;
    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat);
    check("w0_st_lat", lat, 32'd1);
    check("w0_st_err", {31'd0, er}, 32'd0);
    xfer(1'b0, 32'h0000_0010, 32'd0, rd, er, lat);
    check("w0_ld_lat", lat, 32'd1);
    check("w0_ld_rdata", rd, 32'hDEAD_BEEF);
    check("w0_ld_err", {31'd0, er}, 32'd0);
    xfer(1'b0, 32'h0000_1000, 32'd0, rd, er, lat);
    check("w0_oob_err", {31'd0, er}, 32'd1);
    check("w0_oob_rdata", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
